ext_mem_loader: RTL and testbench
=================================

// Module: ext_mem_loader
// PURPOSE
//  Host-side initiator for the CPU's external memory ports (addr_ext/wen_ext/ren_ext/wdata_ext/rdata_ext, *_2 for DMEM).
//  Takes a valid/ready word stream and writes IMEM words, then DMEM words.
//  Then holds cpu enable high for a programmed cycle count.
//  Finally reads back a DMEM window and streams it out on valid/ready. Sits between the test host/UART and cpu.
// PARAMETERS
//  IMEM_ADDR_W  9   IMEM depth = 2**IMEM_ADDR_W 32-bit words
//  DMEM_ADDR_W  10  DMEM depth = 2**DMEM_ADDR_W 64-bit words
//  CNT_W        32  width of run-cycle counter
// PORTS
//  clk          in   1            main clock
//  arst_n       in   1            async reset, active low
//  start        in   1            pulse: begin sequence (sampled in IDLE only)
//  imem_words   in   IMEM_ADDR_W+1  words to load into IMEM (0 = skip)
//  dmem_words   in   DMEM_ADDR_W+1  words to load into DMEM (0 = skip)
//  run_cycles   in   CNT_W        cycles cpu enable stays high (0 = skip)
//  dump_words   in   DMEM_ADDR_W+1  DMEM words to read back from byte addr 0 (0 = skip)
//  in_valid     in   1            input word valid
//  in_ready     out  1            loader accepts word
//  in_data      in   64           input word; IMEM phase uses [31:0]
//  addr_ext     out  64           IMEM ext byte address
//  wen_ext      out  1            IMEM ext write strobe
//  ren_ext      out  1            IMEM ext read strobe (tied 0)
//  wdata_ext    out  32           IMEM ext write data
//  addr_ext_2   out  64           DMEM ext byte address
//  wen_ext_2    out  1            DMEM ext write strobe
//  ren_ext_2    out  1            DMEM ext read strobe
//  wdata_ext_2  out  64           DMEM ext write data
//  rdata_ext_2  in   64           DMEM ext read data, valid 1 cycle after ren_ext_2
//  cpu_enable   out  1            drives cpu enable
//  out_valid    out  1            readback word valid
//  out_ready    in   1            sink accepts readback word
//  out_data     out  64           readback word
//  busy         out  1            high in any state but IDLE/DONE
//  done         out  1            high in DONE
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 (addresses, data, strobes, cpu_enable, in_ready, out_valid, busy, done); counters 0.
//  FSM: IDLE -> LOAD_I -> LOAD_D -> RUN -> DUMP_RD -> DUMP_WT -> DONE. Any phase with count 0 is skipped in the same transition.
//  IDLE: start=1 latches all four counts (clamped to 2**ADDR_W) and moves to first nonzero phase. All zero -> DONE.
//  DONE: start=1 behaves as in IDLE. start is ignored in every other state.
//  LOAD_I/LOAD_D: in_ready=1. Beat accepted (in_valid&in_ready) at edge N drives wen for exactly the cycle after N, with registered addr/data.
//  IMEM byte addr = 4*index; DMEM byte addr = 8*index; index starts at 0 per phase.
//  No beat -> wen 0 and index holds. Phase ends at the edge accepting its last beat; in_ready drops the next cycle.
//  RUN: cpu_enable=1 for exactly run_cycles consecutive cycles (down-counter). All ext strobes stay 0.
//  DUMP_RD: ren_ext_2=1 for one cycle, addr_ext_2 = 8*index.
//  DUMP_WT: capture rdata_ext_2 into out_data and set out_valid. Hold both stable until out_ready.
//  On accept: index+1, then back to DUMP_RD, or to DONE after the last word.
//  Readback throughput is 1 word per >=3 cycles. No ext read is issued while out_valid=1.
//  Never assert wen_ext_2 and ren_ext_2 together. Never assert any ext strobe while cpu_enable=1.
//  Reset mid-operation: immediately to IDLE, strobes and cpu_enable drop asynchronously. Partial memory contents are not restored.
// TESTING
//  1) imem_words=3, others 0, words 0x13,0x93,0x113 back-to-back -> wen_ext on 3 consecutive cycles, addr 0,4,8; done 1 cycle after last write.
//  2) dmem_words=2, in_valid gapped (1,0,0,1) -> exactly two wen_ext_2 pulses at addr 0,8; in_ready stays 1 during the gap.
//  3) run_cycles=5 -> cpu_enable high exactly 5 cycles, no ext strobe meanwhile; run_cycles=0 skips RUN.
//  4) dump_words=2, DMEM model holds 0xAA at 0 and 0xBB at 8, out_ready low 4 cycles -> out_data 0xAA held stable, then 0xBB, then done.
//  5) arst_n pulsed low mid LOAD_D -> all strobes, cpu_enable, in_ready 0 at once; new start reloads from index 0.
//  6) start pulsed during RUN -> ignored; sequence completes unchanged.

Source files
------------

// File: rtl/ext_mem_loader.sv
// Host-side sequencer: loads IMEM then DMEM from a valid/ready stream, runs the cpu, streams a DMEM window back.
// Writes land 1 cycle after the accepting edge; readback is 1 word per >=3 cycles and holds out_data until out_ready.
module ext_mem_loader #(
  parameter int IMEM_ADDR_W = 9,
  parameter int DMEM_ADDR_W = 10,
  parameter int CNT_W       = 32
) (
  input  logic                   clk,
  input  logic                   arst_n,
  input  logic                   start,
  input  logic [IMEM_ADDR_W:0]   imem_words,
  input  logic [DMEM_ADDR_W:0]   dmem_words,
  input  logic [CNT_W-1:0]       run_cycles,
  input  logic [DMEM_ADDR_W:0]   dump_words,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [63:0]            in_data,
  output logic [63:0]            addr_ext,
  output logic                   wen_ext,
  output logic                   ren_ext,
  output logic [31:0]            wdata_ext,
  output logic [63:0]            addr_ext_2,
  output logic                   wen_ext_2,
  output logic                   ren_ext_2,
  output logic [63:0]            wdata_ext_2,
  input  logic [63:0]            rdata_ext_2,
  output logic                   cpu_enable,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [63:0]            out_data,
  output logic                   busy,
  output logic                   done
);

  localparam int IW = IMEM_ADDR_W + 1;
  localparam int DW = DMEM_ADDR_W + 1;
  localparam int XW = (IW > DW) ? IW : DW;
  localparam logic [IW-1:0] IMAX = IW'(1) << IMEM_ADDR_W;
  localparam logic [DW-1:0] DMAX = DW'(1) << DMEM_ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_I, S_LOAD_D, S_RUN, S_DUMP_RD, S_DUMP_WT, S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [XW-1:0]          idx_q, idx_d, idx_inc;
  logic [IW-1:0]          icnt_q, icnt_d;
  logic [DW-1:0]          dcnt_q, dcnt_d, ucnt_q, ucnt_d;
  logic [CNT_W-1:0]       rcnt_q, rcnt_d;
  logic                   wen_q, wen_d, wen2_q, wen2_d;
  logic [IMEM_ADDR_W-1:0] iaddr_q, iaddr_d;
  logic [DMEM_ADDR_W-1:0] daddr_q, daddr_d;
  logic [31:0]            wdata_q, wdata_d;
  logic [63:0]            wdata2_q, wdata2_d;
  logic                   ovld_q, ovld_d;
  logic [63:0]            odata_q, odata_d;
  logic [IW-1:0]          imem_clamp;
  logic [DW-1:0]          dmem_clamp, dump_clamp;

  assign imem_clamp = (imem_words > IMAX) ? IMAX : imem_words;
  assign dmem_clamp = (dmem_words > DMAX) ? DMAX : dmem_words;
  assign dump_clamp = (dump_words > DMAX) ? DMAX : dump_words;
  assign idx_inc    = idx_q + XW'(1);

  // First nonzero phase strictly after 'from'; zero-count phases fall through in the same transition.
  function automatic state_t next_phase(input state_t from, input logic i_nz, input logic d_nz,
                                        input logic r_nz, input logic u_nz);
    state_t s;
    s = S_DONE;
    if (u_nz && from < S_DUMP_RD) s = S_DUMP_RD;
    if (r_nz && from < S_RUN)     s = S_RUN;
    if (d_nz && from < S_LOAD_D)  s = S_LOAD_D;
    if (i_nz && from < S_LOAD_I)  s = S_LOAD_I;
    return s;
  endfunction

  assign in_ready    = (state_q == S_LOAD_I) || (state_q == S_LOAD_D);
  // Trailing write pulses from a load phase must finish before the cpu runs or a read issues.
  assign cpu_enable  = (state_q == S_RUN) && !wen_q && !wen2_q;
  assign ren_ext_2   = (state_q == S_DUMP_RD) && !wen2_q;
  assign ren_ext     = 1'b0;
  assign wen_ext     = wen_q;
  assign wdata_ext   = wdata_q;
  assign addr_ext    = {{(62-IMEM_ADDR_W){1'b0}}, iaddr_q, 2'b00};
  assign wen_ext_2   = wen2_q;
  assign wdata_ext_2 = wdata2_q;
  assign addr_ext_2  = ren_ext_2 ? {{(61-DMEM_ADDR_W){1'b0}}, idx_q[DMEM_ADDR_W-1:0], 3'b000}
                                 : {{(61-DMEM_ADDR_W){1'b0}}, daddr_q, 3'b000};
  assign out_valid   = ovld_q;
  assign out_data    = odata_q;
  assign busy        = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done        = (state_q == S_DONE);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    icnt_d   = icnt_q;
    dcnt_d   = dcnt_q;
    ucnt_d   = ucnt_q;
    rcnt_d   = rcnt_q;
    wen_d    = 1'b0;
    wen2_d   = 1'b0;
    iaddr_d  = iaddr_q;
    daddr_d  = daddr_q;
    wdata_d  = wdata_q;
    wdata2_d = wdata2_q;
    ovld_d   = ovld_q;
    odata_d  = odata_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          icnt_d  = imem_clamp;
          dcnt_d  = dmem_clamp;
          ucnt_d  = dump_clamp;
          rcnt_d  = run_cycles;
          idx_d   = '0;
          state_d = next_phase(S_IDLE, imem_clamp != '0, dmem_clamp != '0,
                               run_cycles != '0, dump_clamp != '0);
        end
      end
      S_LOAD_I: begin
        if (in_valid) begin
          wen_d   = 1'b1;
          iaddr_d = idx_q[IMEM_ADDR_W-1:0];
          wdata_d = in_data[31:0];
          idx_d   = idx_inc;
          if (idx_inc == XW'(icnt_q)) begin
            idx_d   = '0;
            state_d = next_phase(S_LOAD_I, 1'b0, dcnt_q != '0, rcnt_q != '0, ucnt_q != '0);
          end
        end
      end
      S_LOAD_D: begin
        if (in_valid) begin
          wen2_d   = 1'b1;
          daddr_d  = idx_q[DMEM_ADDR_W-1:0];
          wdata2_d = in_data;
          idx_d    = idx_inc;
          if (idx_inc == XW'(dcnt_q)) begin
            idx_d   = '0;
            state_d = next_phase(S_LOAD_D, 1'b0, 1'b0, rcnt_q != '0, ucnt_q != '0);
          end
        end
      end
      S_RUN: begin
        if (cpu_enable) begin
          rcnt_d = rcnt_q - CNT_W'(1);
          if (rcnt_q == CNT_W'(1)) state_d = next_phase(S_RUN, 1'b0, 1'b0, 1'b0, ucnt_q != '0);
        end
      end
      S_DUMP_RD: begin
        if (ren_ext_2) state_d = S_DUMP_WT;
      end
      S_DUMP_WT: begin
        // First cycle captures the read data; afterwards hold until the sink takes it.
        if (!ovld_q) begin
          ovld_d  = 1'b1;
          odata_d = rdata_ext_2;
        end else if (out_ready) begin
          ovld_d = 1'b0;
          if (idx_inc == XW'(ucnt_q)) begin
            idx_d   = '0;
            state_d = S_DONE;
          end else begin
            idx_d   = idx_inc;
            state_d = S_DUMP_RD;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      icnt_q   <= '0;
      dcnt_q   <= '0;
      ucnt_q   <= '0;
      rcnt_q   <= '0;
      wen_q    <= 1'b0;
      wen2_q   <= 1'b0;
      iaddr_q  <= '0;
      daddr_q  <= '0;
      wdata_q  <= '0;
      wdata2_q <= '0;
      ovld_q   <= 1'b0;
      odata_q  <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      icnt_q   <= icnt_d;
      dcnt_q   <= dcnt_d;
      ucnt_q   <= ucnt_d;
      rcnt_q   <= rcnt_d;
      wen_q    <= wen_d;
      wen2_q   <= wen2_d;
      iaddr_q  <= iaddr_d;
      daddr_q  <= daddr_d;
      wdata_q  <= wdata_d;
      wdata2_q <= wdata2_d;
      ovld_q   <= ovld_d;
      odata_q  <= odata_d;
    end
  end

endmodule

// File: tb/tb_ext_mem_loader.sv
// Directed bench for ext_mem_loader with a small DMEM model on the *_2 port.
module tb_ext_mem_loader;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  imem_words = '0;
  logic [10:0] dmem_words = '0;
  logic [31:0] run_cycles = '0;
  logic [10:0] dump_words = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_data = '0;
  logic [63:0] addr_ext, addr_ext_2, wdata_ext_2, rdata_ext_2, out_data;
  logic        wen_ext, ren_ext, wen_ext_2, ren_ext_2, cpu_enable, out_valid, busy, done;
  logic [31:0] wdata_ext;
  logic        out_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [63:0] dmem [0:1023];
  logic [63:0] rdata_q = '0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (wen_ext_2) dmem[addr_ext_2[12:3]] <= wdata_ext_2;
    if (ren_ext_2) rdata_q <= dmem[addr_ext_2[12:3]];
  end
  assign rdata_ext_2 = rdata_q;

  ext_mem_loader dut (
    .clk(clk), .arst_n(arst_n), .start(start),
    .imem_words(imem_words), .dmem_words(dmem_words), .run_cycles(run_cycles), .dump_words(dump_words),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext), .wdata_ext(wdata_ext),
    .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2), .wdata_ext_2(wdata_ext_2),
    .rdata_ext_2(rdata_ext_2), .cpu_enable(cpu_enable),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done)
  );

  // Called at a negedge; returns at the negedge after the edge that sampled start.
  task automatic pulse_start(input int iw, input int dw, input int rc, input int uw);
    imem_words = 10'(iw);
    dmem_words = 11'(dw);
    run_cycles = 32'(rc);
    dump_words = 11'(uw);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++; if ({wen_ext, ren_ext, wen_ext_2, ren_ext_2, cpu_enable, in_ready, out_valid, busy, done} !== 9'b0) begin errors++; $display("FAIL reset_flags: got %b expected 0", {wen_ext, ren_ext, wen_ext_2, ren_ext_2, cpu_enable, in_ready, out_valid, busy, done}); end
    checks++; if ({addr_ext, addr_ext_2, wdata_ext, wdata_ext_2, out_data} !== '0) begin errors++; $display("FAIL reset_data: address/data outputs not zero"); end
    @(negedge clk);
    arst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_imem_load();
    logic [31:0] w [3];
    w[0] = 32'h13; w[1] = 32'h93; w[2] = 32'h113;
    pulse_start(3, 0, 0, 0);
    checks++; if (in_ready !== 1'b1 || busy !== 1'b1 || wen_ext !== 1'b0) begin errors++; $display("FAIL imem_enter: in_ready=%b busy=%b wen=%b expected 1 1 0", in_ready, busy, wen_ext); end
    in_valid = 1'b1;
    in_data = {32'h0, w[0]};
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (wen_ext !== 1'b1 || addr_ext !== 64'(4*k) || wdata_ext !== w[k]) begin errors++; $display("FAIL imem_write k=%0d: wen=%b addr=%h data=%h expected 1 %h %h", k, wen_ext, addr_ext, wdata_ext, 4*k, w[k]); end
      checks++; if (done !== (k == 2) || in_ready !== (k < 2)) begin errors++; $display("FAIL imem_done k=%0d: done=%b in_ready=%b expected %b %b", k, done, in_ready, k == 2, k < 2); end
      if (k < 2) in_data = {32'h0, w[k+1]};
      else in_valid = 1'b0;
    end
    @(negedge clk);
    checks++; if (wen_ext !== 1'b0 || done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL imem_end: wen=%b done=%b busy=%b expected 0 1 0", wen_ext, done, busy); end
  endtask

  task automatic test_dmem_gapped();
    logic [3:0]  v;
    logic [63:0] d [2];
    int beat;
    v = 4'b1001;
    d[0] = 64'h1111_2222_3333_4444;
    d[1] = 64'h5555_6666_7777_8888;
    beat = 0;
    pulse_start(0, 2, 0, 0);
    for (int c = 0; c < 4; c++) begin
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL dmem_ready c=%0d: got %b expected 1", c, in_ready); end
      in_valid = v[c];
      in_data = d[beat];
      @(negedge clk);
      checks++; if (wen_ext_2 !== v[c] || ren_ext_2 !== 1'b0) begin errors++; $display("FAIL dmem_wen c=%0d: wen2=%b ren2=%b expected %b 0", c, wen_ext_2, ren_ext_2, v[c]); end
      if (v[c]) begin
        checks++; if (addr_ext_2 !== 64'(8*beat) || wdata_ext_2 !== d[beat]) begin errors++; $display("FAIL dmem_write beat=%0d: addr=%h data=%h expected %h %h", beat, addr_ext_2, wdata_ext_2, 8*beat, d[beat]); end
        beat++;
      end
    end
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0 || done !== 1'b1) begin errors++; $display("FAIL dmem_end: in_ready=%b done=%b expected 0 1", in_ready, done); end
  endtask

  task automatic test_run();
    int hi, rises;
    logic prev;
    hi = 0; rises = 0; prev = 1'b0;
    pulse_start(0, 0, 5, 0);
    for (int c = 0; c < 12; c++) begin
      if (cpu_enable) begin
        hi++;
        checks++; if ({wen_ext, ren_ext, wen_ext_2, ren_ext_2} !== 4'b0) begin errors++; $display("FAIL run_strobe c=%0d: strobes=%b while cpu_enable", c, {wen_ext, ren_ext, wen_ext_2, ren_ext_2}); end
      end
      if (cpu_enable && !prev) rises++;
      prev = cpu_enable;
      @(negedge clk);
    end
    checks++; if (hi != 5 || rises != 1) begin errors++; $display("FAIL run_count: high=%0d runs=%0d expected 5 1", hi, rises); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL run_done: got %b expected 1", done); end
    hi = 0;
    pulse_start(1, 0, 0, 0);
    in_valid = 1'b1;
    in_data = 64'h77;
    for (int c = 0; c < 6; c++) begin
      if (cpu_enable) hi++;
      @(negedge clk);
      in_valid = 1'b0;
    end
    checks++; if (hi != 0 || done !== 1'b1) begin errors++; $display("FAIL run_skip: high=%0d done=%b expected 0 1", hi, done); end
  endtask

  task automatic test_dump();
    logic [63:0] e [2];
    int n;
    e[0] = 64'hAA; e[1] = 64'hBB;
    dmem[0] = 64'hAA;
    dmem[1] = 64'hBB;
    out_ready = 1'b0;
    pulse_start(0, 0, 0, 2);
    for (int w = 0; w < 2; w++) begin
      n = 0;
      while (!out_valid && n < 10) begin
        if (ren_ext_2) begin
          checks++; if (addr_ext_2 !== 64'(8*w) || wen_ext_2 !== 1'b0) begin errors++; $display("FAIL dump_read w=%0d: addr=%h wen2=%b expected %h 0", w, addr_ext_2, wen_ext_2, 8*w); end
        end
        @(negedge clk);
        n++;
      end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL dump_timeout w=%0d: out_valid=%b expected 1", w, out_valid); end
      for (int h = 0; h < 4; h++) begin
        checks++; if (out_valid !== 1'b1 || out_data !== e[w] || ren_ext_2 !== 1'b0) begin errors++; $display("FAIL dump_hold w=%0d h=%0d: valid=%b data=%h ren2=%b expected 1 %h 0", w, h, out_valid, out_data, ren_ext_2, e[w]); end
        @(negedge clk);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL dump_accept w=%0d: out_valid=%b expected 0", w, out_valid); end
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL dump_done: got %b expected 1", done); end
  endtask

  task automatic test_reset_mid_load();
    pulse_start(0, 4, 0, 0);
    in_valid = 1'b1;
    in_data = 64'hD0;
    @(negedge clk);
    in_data = 64'hD1;
    @(negedge clk);
    checks++; if (wen_ext_2 !== 1'b1 || addr_ext_2 !== 64'h8) begin errors++; $display("FAIL rst_pre: wen2=%b addr=%h expected 1 8", wen_ext_2, addr_ext_2); end
    #1 arst_n = 1'b0;
    #1;
    checks++; if ({wen_ext_2, wen_ext, ren_ext_2, cpu_enable, in_ready, busy} !== 6'b0) begin errors++; $display("FAIL rst_async: wen2,wen,ren2,cpu_en,in_ready,busy=%b expected 0", {wen_ext_2, wen_ext, ren_ext_2, cpu_enable, in_ready, busy}); end
    in_valid = 1'b0;
    @(negedge clk);
    arst_n = 1'b1;
    @(negedge clk);
    pulse_start(0, 2, 0, 0);
    in_valid = 1'b1;
    in_data = 64'hE0;
    @(negedge clk);
    checks++; if (wen_ext_2 !== 1'b1 || addr_ext_2 !== 64'h0 || wdata_ext_2 !== 64'hE0) begin errors++; $display("FAIL rst_reload0: wen2=%b addr=%h data=%h expected 1 0 e0", wen_ext_2, addr_ext_2, wdata_ext_2); end
    in_data = 64'hE1;
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (addr_ext_2 !== 64'h8 || done !== 1'b1) begin errors++; $display("FAIL rst_reload1: addr=%h done=%b expected 8 1", addr_ext_2, done); end
  endtask

  task automatic test_start_during_run();
    int hi;
    hi = 0;
    pulse_start(0, 0, 4, 0);
    for (int c = 0; c < 12; c++) begin
      if (cpu_enable) hi++;
      if (c == 2) begin
        start = 1'b1;
        run_cycles = 32'd9;
        imem_words = 10'd3;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    checks++; if (hi != 4) begin errors++; $display("FAIL run_restart_count: high=%0d expected 4", hi); end
    checks++; if (done !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL run_restart_done: done=%b in_ready=%b expected 1 0", done, in_ready); end
  endtask

  initial begin
    test_reset();
    test_imem_load();
    test_dmem_gapped();
    test_run();
    test_dump();
    test_reset_mid_load();
    test_start_during_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
